// File: rtl/check_pkg.sv
// Shared command codes, meta byte and FSM state encoding for the result checker.
package check_pkg;

    localparam logic [4:0] SC_CMD_IDLE    = 5'b00000;
    localparam logic [4:0] SC_CMD_BITMASK = 5'b00001;
    localparam logic [4:0] SC_CMD_MODE    = 5'b00010;
    localparam logic [4:0] SC_CMD_CLR_CNT = 5'b00011;

    localparam logic [7:0] META_RUN = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_FIFOS  = 2'd1,
        ST_CMP       = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    function automatic int nwords(input int rtf_width, input int data_width);
        return (rtf_width + 8 + data_width - 1) / data_width;
    endfunction

endpackage

// File: rtl/check_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module check_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/check_multi.sv
// Pops a result/expected pair, compares under a bitmask and writes a packed record over Avalon-MM.
// state | meaning: IDLE wait for both FIFOs | RD_FIFOS pop both | CMP latch compare | WRITEBACK emit words
module check_multi
    import check_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int RTF_WIDTH  = 24,
    parameter int ORV_WIDTH  = 8,
    parameter int CHF_WIDTH  = RTF_WIDTH + ORV_WIDTH + ADDR_WIDTH,
    parameter int SCC_WIDTH  = 5,
    parameter int SCD_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic                  mem_waitrequest,
    input  logic [RTF_WIDTH-1:0]  rfifo_data,
    output logic                  rfifo_rdreq,
    input  logic                  rfifo_rdempty,
    input  logic [CHF_WIDTH-1:0]  cfifo_data,
    output logic                  cfifo_rdreq,
    input  logic                  cfifo_rdempty,
    input  logic [SCC_WIDTH-1:0]  sc_cmd,
    input  logic [SCD_WIDTH-1:0]  sc_data,
    output logic                  sc_ready,
    output logic [CNT_WIDTH-1:0]  vec_count,
    output logic [CNT_WIDTH-1:0]  fail_count
);

    localparam int NWORDS = nwords(RTF_WIDTH, DATA_WIDTH);
    localparam int PW     = NWORDS * DATA_WIDTH;
    localparam int PAD    = PW - RTF_WIDTH - 8;
    localparam int WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(NWORDS - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WW-1:0]         r_word;
    logic [RTF_WIDTH-1:0]  r_bitmask;
    logic [RTF_WIDTH-1:0]  r_res;
    logic                  r_fail;
    logic                  r_fail_only;
    logic                  r_mem_write;
    logic                  r_rdreq;

    logic [RTF_WIDTH-1:0]           w_exp;
    logic [ADDR_WIDTH-1:0]          w_cf_addr;
    logic [RTF_WIDTH-1:0]           w_masked_res;
    logic [RTF_WIDTH-1:0]           w_masked_exp;
    logic                           w_fail;
    logic                           w_accept;
    logic                           w_in_cmp;
    logic                           w_cmd_mask;
    logic                           w_cmd_mode;
    logic                           w_cmd_clr;
    logic [RTF_WIDTH+SCD_WIDTH-1:0] w_sc_ext;
    logic [7:0]                     w_meta;
    logic [PW-1:0]                  w_packed;
    logic [DATA_WIDTH-1:0]          w_words [NWORDS];
    logic                           w_unused;

    assign w_exp        = cfifo_data[CHF_WIDTH-1 -: RTF_WIDTH];
    assign w_cf_addr    = cfifo_data[ORV_WIDTH +: ADDR_WIDTH];
    assign w_masked_res = rfifo_data & r_bitmask;
    assign w_masked_exp = w_exp & r_bitmask;
    assign w_fail       = (w_masked_res != w_masked_exp);
    assign w_accept     = r_mem_write && !mem_waitrequest;
    assign w_in_cmp     = (r_state == ST_CMP);

    assign w_cmd_mask = (sc_cmd == SCC_WIDTH'(SC_CMD_BITMASK));
    assign w_cmd_mode = (sc_cmd == SCC_WIDTH'(SC_CMD_MODE));
    assign w_cmd_clr  = (sc_cmd == SCC_WIDTH'(SC_CMD_CLR_CNT));
    assign w_sc_ext   = {{RTF_WIDTH{1'b0}}, sc_data};

    // OR value and the truncated part of sc_data are intentionally dropped
    assign w_unused = ^{cfifo_data[ORV_WIDTH-1:0], w_sc_ext[RTF_WIDTH+SCD_WIDTH-1:RTF_WIDTH]};

    // Record built from latched values so a bitmask change mid-writeback cannot alter it
    assign w_meta   = META_RUN | {7'd0, r_fail};
    assign w_packed = PW'({r_res, w_meta}) << PAD;

    always_comb begin
        for (int k = 0; k < NWORDS; k++) begin
            w_words[k] = w_packed[PW-1-k*DATA_WIDTH -: DATA_WIDTH];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_word      <= '0;
            r_res       <= '0;
            r_fail      <= 1'b0;
            r_mem_write <= 1'b0;
            r_rdreq     <= 1'b0;
        end else begin
            r_rdreq <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!rfifo_rdempty && !cfifo_rdempty) begin
                        r_state <= ST_RD_FIFOS;
                        r_rdreq <= 1'b1;
                    end
                end
                ST_RD_FIFOS: r_state <= ST_CMP;
                ST_CMP: begin
                    r_res  <= w_masked_res;
                    r_fail <= w_fail;
                    r_addr <= w_cf_addr;
                    if (r_fail_only && !w_fail) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state     <= ST_WRITEBACK;
                        r_mem_write <= 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    if (w_accept) begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                        if (r_word == LAST_WORD) begin
                            r_word      <= '0;
                            r_mem_write <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_word <= r_word + WW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bitmask   <= '1;
            r_fail_only <= 1'b0;
        end else begin
            if (w_cmd_mask) r_bitmask <= w_sc_ext[RTF_WIDTH-1:0];
            if (w_cmd_mode) r_fail_only <= sc_data[0];
        end
    end

    check_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_vec_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_in_cmp),
        .i_clr   (w_cmd_clr),
        .o_count (vec_count)
    );

    check_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fail_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_in_cmp && w_fail),
        .i_clr   (w_cmd_clr),
        .o_count (fail_count)
    );

    assign mem_address    = r_addr;
    assign mem_byteenable = '1;
    assign mem_write      = r_mem_write;
    assign mem_writedata  = w_words[r_word];
    assign rfifo_rdreq    = r_rdreq;
    assign cfifo_rdreq    = r_rdreq;
    assign sc_ready       = (r_state == ST_IDLE) && rfifo_rdempty && cfifo_rdempty;

endmodule

// File: tb/tb_check_multi.sv
// Randomized bench for check_multi: default instance plus a 40-bit / 4-bit-counter instance.
module tb_check_multi;
    import check_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- unit 0: default parameters ----------------
    logic [19:0] mem_address0;
    logic [1:0]  mem_be0;
    logic        mem_write0;
    logic [15:0] mem_wd0;
    logic        mem_wait0 = 1'b0;
    logic [23:0] rdata0 = '0;
    logic        rreq0;
    logic        rempty0 = 1'b1;
    logic [51:0] cdata0 = '0;
    logic        creq0;
    logic        cempty0 = 1'b1;
    logic [4:0]  sc_cmd0 = SC_CMD_IDLE;
    logic [23:0] sc_data0 = '0;
    logic        ready0;
    logic [15:0] vcnt0, fcnt0;

    check_multi dut0 (
        .clock(clock), .reset(reset),
        .mem_address(mem_address0), .mem_byteenable(mem_be0), .mem_write(mem_write0),
        .mem_writedata(mem_wd0), .mem_waitrequest(mem_wait0),
        .rfifo_data(rdata0), .rfifo_rdreq(rreq0), .rfifo_rdempty(rempty0),
        .cfifo_data(cdata0), .cfifo_rdreq(creq0), .cfifo_rdempty(cempty0),
        .sc_cmd(sc_cmd0), .sc_data(sc_data0), .sc_ready(ready0),
        .vec_count(vcnt0), .fail_count(fcnt0)
    );

    logic [23:0] rq0[$];
    logic [51:0] cq0[$];
    logic [35:0] obs0[$];
    logic [35:0] ex0[$];
    int          pops0 = 0, pushes0 = 0;
    int          wmode = 0;
    logic        wforce = 1'b0;
    logic [23:0] m_mask0 = 24'hFFFFFF;
    logic        m_fo0 = 1'b0;
    int          m_vec0 = 0, m_fail0 = 0;
    logic        p_hold0 = 1'b0;
    logic [35:0] p_aw0 = '0;

    always @(posedge clock) begin
        if (rreq0 || creq0) begin
            chk("pop_pair0", {rreq0, creq0, rq0.size() > 0, cq0.size() > 0}, 4'hF);
            if (rq0.size() > 0) rdata0 <= rq0.pop_front();
            if (cq0.size() > 0) cdata0 <= cq0.pop_front();
            pops0++;
        end
        rempty0 <= (rq0.size() == 0);
        cempty0 <= (cq0.size() == 0);
    end

    always @(posedge clock) begin
        if (p_hold0) chk("wait_hold0", {mem_write0, mem_address0, mem_wd0}, {1'b1, p_aw0});
        if (mem_write0 && !mem_wait0 && !reset) obs0.push_back({mem_address0, mem_wd0});
        p_hold0 <= mem_write0 && mem_wait0 && !reset;
        p_aw0   <= {mem_address0, mem_wd0};
    end

    always @(negedge clock) begin
        if (wmode == 1) mem_wait0 = ($urandom_range(0, 3) == 0);
        else            mem_wait0 = wforce;
    end

    task automatic push0(input logic [23:0] res, input logic [23:0] exp, input logic [19:0] addr);
        logic [23:0] mr;
        logic        fl;
        logic [31:0] rec;
        rq0.push_back(res);
        cq0.push_back({exp, addr, 8'($urandom)});
        pushes0++;
        mr = res & m_mask0;
        fl = (mr != (exp & m_mask0));
        if (m_vec0 < 65535) m_vec0++;
        if (fl && m_fail0 < 65535) m_fail0++;
        if (fl || !m_fo0) begin
            rec = 32'(mr) * 256 + 32'd128 + 32'(fl);
            ex0.push_back({addr, rec[31:16]});
            ex0.push_back({addr + 20'd1, rec[15:0]});
        end
    endtask

    task automatic set_cmd0(input logic [4:0] c, input logic [23:0] d);
        @(negedge clock);
        sc_cmd0  = c;
        sc_data0 = d;
        @(negedge clock);
        sc_cmd0  = SC_CMD_IDLE;
        sc_data0 = 24'($urandom);
    endtask

    task automatic wait_ready0(input string tag);
        int n = 0;
        repeat (3) @(negedge clock);
        while (!ready0 && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_ready"}, ready0, 1'b1);
    endtask

    task automatic cmp_log0(input string tag);
        chk({tag, "_nwr"}, obs0.size(), ex0.size());
        for (int i = 0; i < obs0.size() && i < ex0.size(); i++) chk({tag, "_wr"}, obs0[i], ex0[i]);
        chk({tag, "_vec"}, vcnt0, m_vec0);
        chk({tag, "_fail"}, fcnt0, m_fail0);
        chk({tag, "_pops"}, pops0, pushes0);
        obs0.delete();
        ex0.delete();
    endtask

    // ---------------- unit 1: RTF=40 (3 words), 4-bit counters ----------------
    logic [19:0] mem_address1;
    logic [1:0]  mem_be1;
    logic        mem_write1;
    logic [15:0] mem_wd1;
    logic        mem_wait1 = 1'b0;
    logic [39:0] rdata1 = '0;
    logic        rreq1;
    logic        rempty1 = 1'b1;
    logic [67:0] cdata1 = '0;
    logic        creq1;
    logic        cempty1 = 1'b1;
    logic [4:0]  sc_cmd1 = SC_CMD_IDLE;
    logic [23:0] sc_data1 = '0;
    logic        ready1;
    logic [3:0]  vcnt1, fcnt1;

    check_multi #(.RTF_WIDTH(40), .CNT_WIDTH(4)) dut1 (
        .clock(clock), .reset(reset),
        .mem_address(mem_address1), .mem_byteenable(mem_be1), .mem_write(mem_write1),
        .mem_writedata(mem_wd1), .mem_waitrequest(mem_wait1),
        .rfifo_data(rdata1), .rfifo_rdreq(rreq1), .rfifo_rdempty(rempty1),
        .cfifo_data(cdata1), .cfifo_rdreq(creq1), .cfifo_rdempty(cempty1),
        .sc_cmd(sc_cmd1), .sc_data(sc_data1), .sc_ready(ready1),
        .vec_count(vcnt1), .fail_count(fcnt1)
    );

    logic [39:0] rq1[$];
    logic [67:0] cq1[$];
    logic [35:0] obs1[$];
    logic [35:0] ex1[$];
    int          m_vec1 = 0, m_fail1 = 0;

    always @(posedge clock) begin
        if (rreq1 || creq1) begin
            chk("pop_pair1", {rreq1, creq1, rq1.size() > 0, cq1.size() > 0}, 4'hF);
            if (rq1.size() > 0) rdata1 <= rq1.pop_front();
            if (cq1.size() > 0) cdata1 <= cq1.pop_front();
        end
        rempty1 <= (rq1.size() == 0);
        cempty1 <= (cq1.size() == 0);
        if (mem_write1 && !mem_wait1 && !reset) obs1.push_back({mem_address1, mem_wd1});
    end

    task automatic push1(input logic [39:0] res, input logic [39:0] exp, input logic [19:0] addr);
        logic        fl;
        logic [47:0] rec;
        rq1.push_back(res);
        cq1.push_back({exp, addr, 8'h00});
        fl = (res != exp);
        if (m_vec1 < 15) m_vec1++;
        if (fl && m_fail1 < 15) m_fail1++;
        rec = 48'(res) * 256 + 48'd128 + 48'(fl);
        for (int k = 0; k < 3; k++) ex1.push_back({addr + 20'(k), rec[47-16*k -: 16]});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          n;
        int          p;
        logic [23:0] res, exp, mk;
        logic [19:0] addr;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_wr", mem_write0, 1'b0);
        chk("rst_rreq", {rreq0, creq0}, 2'b00);
        chk("rst_cnt", {vcnt0, fcnt0}, 32'h0);
        chk("rst_ready", ready0, 1'b1);

        // basic record
        push0(24'hABCDEF, 24'hABCDEF, 20'h00100);
        wait_ready0("t1");
        chk("t1_w0", (obs0.size() > 0) ? obs0[0] : 36'h0, {20'h00100, 16'hABCD});
        chk("t1_w1", (obs0.size() > 1) ? obs0[1] : 36'h0, {20'h00101, 16'hEF80});
        cmp_log0("t1");

        // bitmask hides the LSB difference, then full mask exposes it
        set_cmd0(SC_CMD_BITMASK, 24'hFFFFFE);
        m_mask0 = 24'hFFFFFE;
        push0(24'hABCDEF, 24'hABCDEE, 20'h00300);
        wait_ready0("t2a");
        chk("t2a_w1", (obs0.size() > 1) ? obs0[1][15:0] : 16'h0, 16'hEE80);
        cmp_log0("t2a");
        set_cmd0(SC_CMD_BITMASK, 24'hFFFFFF);
        m_mask0 = 24'hFFFFFF;
        push0(24'hABCDEF, 24'hABCDEE, 20'h00300);
        wait_ready0("t2b");
        chk("t2b_w1", (obs0.size() > 1) ? obs0[1][15:0] : 16'h0, 16'hEF81);
        chk("t2b_fcnt", fcnt0, 16'd1);
        cmp_log0("t2b");

        // fail-only: five passes then one fail
        set_cmd0(SC_CMD_CLR_CNT, 24'h0);
        m_vec0 = 0;
        m_fail0 = 0;
        set_cmd0(SC_CMD_MODE, 24'h1);
        m_fo0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            res = 24'($urandom);
            push0(res, res, 20'($urandom));
        end
        push0(24'h123456, 24'h123457, 20'h00200);
        wait_ready0("t3");
        chk("t3_nwr", obs0.size(), 2);
        chk("t3_addr", (obs0.size() > 1) ? {obs0[0][35:16], obs0[1][35:16]} : 40'h0, {20'h00200, 20'h00201});
        chk("t3_cnt", {vcnt0, fcnt0}, {16'd6, 16'd1});
        cmp_log0("t3");
        set_cmd0(SC_CMD_MODE, 24'h0);
        m_fo0 = 1'b0;

        // waitrequest held on word 0
        wforce = 1'b1;
        push0(24'h5A5A5A, 24'h5A5A5A, 20'h00444);
        n = 0;
        while (!mem_write0 && n < 50) begin @(negedge clock); n++; end
        repeat (3) @(negedge clock);
        chk("t4_stall", {mem_write0, mem_address0, 8'(obs0.size())}, {1'b1, 20'h00444, 8'd0});
        wforce = 1'b0;
        wait_ready0("t4");
        cmp_log0("t4");

        // CLR_CNT coincident with CMP
        push0(24'h000001, 24'h000002, 20'h00500);
        n = 0;
        while (!rreq0 && n < 50) begin @(negedge clock); n++; end
        chk("t5_sync", rreq0, 1'b1);
        @(negedge clock);
        sc_cmd0 = SC_CMD_CLR_CNT;
        @(negedge clock);
        sc_cmd0 = SC_CMD_IDLE;
        m_vec0 = 0;
        m_fail0 = 0;
        wait_ready0("t5");
        chk("t5_cnt", {vcnt0, fcnt0}, 32'h0);
        cmp_log0("t5");

        // randomized traffic
        wmode = 1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                mk = ($urandom_range(0, 1) == 1) ? 24'hFFFFFF : 24'($urandom);
                set_cmd0(SC_CMD_BITMASK, mk);
                m_mask0 = mk;
            end
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, 1);
                set_cmd0(SC_CMD_MODE, 24'(p));
                m_fo0 = (p == 1);
            end
            if ($urandom_range(0, 7) == 0) begin
                set_cmd0(SC_CMD_CLR_CNT, 24'($urandom));
                m_vec0 = 0;
                m_fail0 = 0;
            end
            if ($urandom_range(0, 5) == 0) set_cmd0(5'($urandom_range(4, 31)), 24'($urandom));
            for (int j = 0; j < $urandom_range(1, 3); j++) begin
                res = 24'($urandom);
                case ($urandom_range(0, 2))
                    0:       exp = res;
                    1:       exp = res ^ (24'd1 << $urandom_range(0, 23));
                    default: exp = 24'($urandom);
                endcase
                addr = ($urandom_range(0, 3) == 0) ? 20'hFFFFF - 20'($urandom_range(0, 1)) : 20'($urandom);
                push0(res, exp, addr);
            end
            wait_ready0("rnd");
            cmp_log0("rnd");
        end
        wmode = 0;

        // reset in the middle of writeback
        wforce = 1'b1;
        push0(24'h111111, 24'h222222, 20'h00600);
        n = 0;
        while (!mem_write0 && n < 50) begin @(negedge clock); n++; end
        chk("t6_pre", mem_write0, 1'b1);
        p = pops0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t6_wr", mem_write0, 1'b0);
        chk("t6_ready", ready0, 1'b1);
        chk("t6_cnt", {vcnt0, fcnt0}, 32'h0);
        repeat (3) @(negedge clock);
        chk("t6_quiet", {mem_write0, rreq0, 8'(pops0 - p), 8'(obs0.size())}, 18'h0);
        wforce = 1'b0;
        ex0.delete();
        pushes0 = pops0;
        m_mask0 = 24'hFFFFFF;
        m_fo0 = 1'b0;
        m_vec0 = 0;
        m_fail0 = 0;
        push0(24'hC0FFEE, 24'hC0FFEE, 20'h00700);
        wait_ready0("t6b");
        cmp_log0("t6b");

        // 40-bit record, address wrap, then 4-bit counter saturation
        push1(40'h123456789A, 40'h123456789A, 20'hFFFFF);
        repeat (3) @(negedge clock);
        n = 0;
        while (!ready1 && n < 500) begin @(negedge clock); n++; end
        chk("w40_ready", ready1, 1'b1);
        chk("w40_nwr", obs1.size(), 3);
        chk("w40_w0", (obs1.size() > 0) ? obs1[0] : 36'h0, {20'hFFFFF, 16'h1234});
        chk("w40_w1", (obs1.size() > 1) ? obs1[1] : 36'h0, {20'h00000, 16'h5678});
        chk("w40_w2", (obs1.size() > 2) ? obs1[2] : 36'h0, {20'h00001, 16'h9A80});
        obs1.delete();
        ex1.delete();
        for (int i = 0; i < 17; i++) push1({8'h00, 32'($urandom)}, 40'hFF_0000_0000, 20'($urandom));
        repeat (3) @(negedge clock);
        n = 0;
        while (!ready1 && n < 1000) begin @(negedge clock); n++; end
        chk("sat_ready", ready1, 1'b1);
        chk("sat_nwr", obs1.size(), ex1.size());
        for (int i = 0; i < obs1.size() && i < ex1.size(); i++) chk("sat_wr", obs1[i], ex1[i]);
        chk("sat_cnt", {vcnt1, fcnt1}, {4'(m_vec1), 4'(m_fail1)});
        chk("sat_const", {vcnt1, fcnt1}, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
